// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding, tag-width rule and round-robin pointer step.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit tag so the FIFO word layout stays fixed.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above i_start, wrapping at N-1 -> 0.
// Purely combinational, no backpressure of its own.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_start,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;
  int             sum;

  assign req_dbl = {i_req, i_req};
  assign req_rot = req_dbl >> i_start;

  // Scan from the far end so the last hit written is the nearest one to i_start.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    sum     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum     = int'(i_start) + k;
        o_found = 1'b1;
        o_idx   = IDW'((sum >= N) ? (sum - N) : sum);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; grant registered one cycle after request,
// writes are same-cycle handshakes. i_fifo_full stalls a held grant, almost_full only blocks new grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_REQ    = 4,
  parameter int  MAX_BURST  = 4,
  localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_s_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [DATA_WIDTH-1:0]        i_req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] o_wr_data,
  input  logic                         i_fifo_full,
  input  logic                         i_fifo_almost_full,
  output logic [ID_WIDTH-1:0]          o_grant_id,
  output logic                         o_busy
);

  localparam int                   CNT_WIDTH   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] BURST_LIMIT = CNT_WIDTH'(MAX_BURST);

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 xfer;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_start (rr_ptr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    o_req_ready = '0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found && !i_fifo_full && !i_fifo_almost_full) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Reset gates acceptance so a word offered during reset is never lost silently.
        o_req_ready[grant_q] = !i_fifo_full && i_s_rst_n;
        xfer = i_req_valid[grant_q] && o_req_ready[grant_q];
        if (xfer) begin
          o_wr_en   = 1'b1;
          o_wr_data = {grant_q, i_req_data[grant_q]};
          cnt_d     = cnt_inc;
          if (i_req_last[grant_q] || (cnt_inc == BURST_LIMIT)) begin
            state_d  = IDLE;
            rr_ptr_d = ID_WIDTH'(next_rr(int'(grant_q), NUM_REQ));
          end
        end else if (!i_req_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = ID_WIDTH'(next_rr(int'(grant_q), NUM_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_grant_id = grant_q;
  assign o_busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand sequences and random traffic
// checked against a transaction-level model of the grant/burst rules.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid;
  logic [DW-1:0] data [N];
  logic [N-1:0]  last;
  logic [N-1:0]  ready;
  logic          wr_en;
  logic [9:0]    wr_data;
  logic          full;
  logic          afull;
  logic [1:0]    gid;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk              (clk),
    .i_s_rst_n          (rst_n),
    .i_req_valid        (valid),
    .i_req_data         (data),
    .i_req_last         (last),
    .o_req_ready        (ready),
    .o_wr_en            (wr_en),
    .o_wr_data          (wr_data),
    .i_fifo_full        (full),
    .i_fifo_almost_full (afull),
    .o_grant_id         (gid),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: who holds the grant (-1 = nobody), words sent, fairness pointer.
  int m_grant = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_gid   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_grant = -1; m_cnt = 0; m_ptr = 0; m_gid = 0;
    end else if (m_grant < 0) begin
      if (!full && !afull) begin
        for (int k = 0; k < N; k++) begin
          if (valid[(m_ptr + k) % N]) begin
            m_grant = (m_ptr + k) % N;
            m_gid   = m_grant;
            m_cnt   = 0;
            break;
          end
        end
      end
    end else begin
      if (valid[m_grant] && !full) begin
        m_cnt++;
        if (last[m_grant] || m_cnt == MB) begin
          m_ptr = (m_grant + 1) % N; m_grant = -1;
        end
      end else if (!valid[m_grant]) begin
        m_ptr = (m_grant + 1) % N; m_grant = -1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [3:0] er, input logic ew,
                     input logic [9:0] ed, input logic [1:0] eg, input logic eb);
    n_vec++;
    if (ready !== er || wr_en !== ew || wr_data !== ed || gid !== eg || busy !== eb) begin
      n_bad++;
      $display("FAIL %s t=%0t: got rdy=%b wr=%b dat=%h gid=%0d busy=%b, want rdy=%b wr=%b dat=%h gid=%0d busy=%b",
               nm, $time, ready, wr_en, wr_data, gid, busy, er, ew, ed, eg, eb);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic model_check();
    logic [3:0] er;
    logic       ew;
    logic [9:0] ed;
    er = '0; ew = 1'b0; ed = '0;
    if (m_grant >= 0 && rst_n && !full) begin
      er = 4'(1 << m_grant);
      if (valid[m_grant]) begin
        ew = 1'b1;
        ed = {2'(m_grant), data[m_grant]};
      end
    end
    cmp("model", er, ew, ed, 2'(m_gid), m_grant >= 0);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic af, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; valid = v; last = l; full = f; afull = af;
    for (int i = 0; i < N; i++) data[i] = d + 8'(i);
    #1;
    model_check();
  endtask

  typedef struct {
    logic       r;
    logic [3:0] v, l;
    logic       f, af;
    logic [7:0] d;
    logic [3:0] er;
    logic       ew;
    logic [9:0] ed;
    logic [1:0] eg;
    logic       eb;
  } vec_t;

  vec_t tbl [18];
  int   wr_cnt;
  int   gids [$];

  initial begin
    tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA0, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA1, 4'b0001, 1'b1, 10'h0A1, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA2, 4'b0001, 1'b1, 10'h0A2, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'hA3, 4'b0001, 1'b1, 10'h0A3, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB0, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB1, 4'b0010, 1'b1, 10'h1B2, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'hB1, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'hB1, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB3, 4'b0010, 1'b1, 10'h1B4, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB5, 4'b0010, 1'b1, 10'h1B6, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB7, 4'b0010, 1'b1, 10'h1B8, 2'd1, 1'b1};
    tbl[12] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'hB9, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b0, 10'h000, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'hC0, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b0};
    tbl[15] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'hC0, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b0};
    tbl[16] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hC0, 4'b0000, 1'b0, 10'h000, 2'd1, 1'b0};
    tbl[17] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'hC1, 4'b0001, 1'b1, 10'h0C1, 2'd0, 1'b1};

    rst_n = 1'b0; valid = '0; last = '0; full = 1'b0; afull = 1'b0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (2) @(posedge clk);

    // Directed table: single packet, full stall, burst limit, valid-drop release, almost_full gating.
    for (int t = 0; t < 18; t++) begin
      drive(tbl[t].r, tbl[t].v, tbl[t].l, tbl[t].f, tbl[t].af, tbl[t].d);
      cmp($sformatf("vec%0d", t), tbl[t].er, tbl[t].ew, tbl[t].ed, tbl[t].eg, tbl[t].eb);
    end

    // All requesters saturated: 4-word bursts, order 0,1,2,3,0, one dead cycle between.
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
    wr_cnt = 0;
    gids.delete();
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'(c * 7));
      if (wr_en) begin
        wr_cnt++;
        gids.push_back(int'(gid));
      end
    end
    cmp_int("rr_writes", wr_cnt, 20);
    for (int k = 0; k < gids.size(); k++) cmp_int($sformatf("rr_order%0d", k), gids[k], (k / 4) % 4);

    // Reset in the middle of requester 1's burst.
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h10);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h20);
    cmp("mid_w1", 4'b0010, 1'b1, {2'd1, 8'h21}, 2'd1, 1'b1);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h30);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h40);
    cmp("rst_cycle", 4'b0000, 1'b0, 10'h000, 2'd1, 1'b1);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h50);
    cmp("after_rst", 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h60);
    cmp("regrant0", 4'b0001, 1'b1, {2'd0, 8'h60}, 2'd0, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(299) != 0,
            4'($urandom_range(15) | $urandom_range(15)),
            4'($urandom_range(15) & $urandom_range(15)),
            $urandom_range(4) == 0,
            $urandom_range(5) == 0,
            8'($urandom));
      if (wr_en && full) begin
        n_bad++;
        $display("FAIL wr_while_full t=%0t: got wr_en=1 full=1, want wr_en=0", $time);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
